fixed_point_acc_ctrl: RTL and testbench

FIXED_POINT_ACC_CTRL -- requirements
Module: fixed_point_acc_ctrl

---
 rtl/fixed_point_acc_ctrl_pkg.sv | 15 +
 rtl/fixed_point_add.sv | 46 ++++
 rtl/fixed_point_acc_ctrl.sv | 113 +++++++++++
 tb/tb_fixed_point_acc_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_acc_ctrl_pkg.sv
// Shared constants for the fixed-point accumulator controller: number format,
// default sizing and FSM state encoding.
package fixed_point_acc_ctrl_pkg;

    localparam int unsigned INT_BITS    = 4;
    localparam int unsigned FRAC_BITS   = 15;
    localparam int unsigned BITSIZE_DEF = 1 + INT_BITS + FRAC_BITS;
    localparam int unsigned MAX_LEN_DEF = 16;
    localparam int unsigned CNT_W_DEF   = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/fixed_point_add.sv
// Combinational sign-magnitude adder; same-sign overflow clamps the magnitude
// to all ones. An exact cancellation keeps the sign of operand a.
module fixed_point_add
    import fixed_point_acc_ctrl_pkg::*;
#(
    parameter int unsigned BITSIZE = BITSIZE_DEF
) (
    input  logic [BITSIZE-1:0] a_i,
    input  logic [BITSIZE-1:0] b_i,
    output logic [BITSIZE-1:0] sum_c
);

    localparam int unsigned MAG_W = BITSIZE - 1;

    logic             sign_a;
    logic             sign_b;
    logic [MAG_W-1:0] mag_a;
    logic [MAG_W-1:0] mag_b;
    logic [MAG_W:0]   mag_sum;
    logic             sign_r;
    logic [MAG_W-1:0] mag_r;

    assign sign_a  = a_i[BITSIZE-1];
    assign sign_b  = b_i[BITSIZE-1];
    assign mag_a   = a_i[MAG_W-1:0];
    assign mag_b   = b_i[MAG_W-1:0];
    assign mag_sum = {1'b0, mag_a} + {1'b0, mag_b};

    always_comb begin
        sign_r = sign_a;
        mag_r  = mag_a;
        if (sign_a == sign_b) begin
            sign_r = sign_a;
            mag_r  = mag_sum[MAG_W] ? {MAG_W{1'b1}} : mag_sum[MAG_W-1:0];
        end else if (mag_a >= mag_b) begin
            sign_r = sign_a;
            mag_r  = mag_a - mag_b;
        end else begin
            sign_r = sign_b;
            mag_r  = mag_b - mag_a;
        end
    end

    assign sum_c = {sign_r, mag_r};

endmodule

// File: rtl/fixed_point_acc_ctrl.sv
// Streaming accumulator: sums a start-specified number of sign-magnitude
// operands through one saturating adder and hands the result off with valid/ready.
module fixed_point_acc_ctrl
    import fixed_point_acc_ctrl_pkg::*;
#(
    parameter int unsigned BITSIZE = BITSIZE_DEF,
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BITSIZE-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BITSIZE-1:0] out_data,
    output logic               busy,
    output logic               sat_flag
);

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [BITSIZE-1:0] acc_q;
    logic [BITSIZE-1:0] acc_d;
    logic [CNT_W-1:0]   rem_q;
    logic [CNT_W-1:0]   rem_d;
    logic               sat_q;
    logic               sat_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic [BITSIZE-1:0] sum;
    logic [CNT_W-1:0]   len_clamped;

    fixed_point_add #(
        .BITSIZE (BITSIZE)
    ) u_add (
        .a_i   (acc_q),
        .b_i   (in_data),
        .sum_c (sum)
    );

    assign len_clamped = (len > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : len;

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        sat_d   = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    rem_d   = len_clamped;
                    state_d = (len_clamped == '0) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (in_valid) begin
                    acc_d = sum;
                    rem_d = rem_q - CNT_W'(1);
                    if (&sum[BITSIZE-2:0]) begin
                        sat_d = 1'b1;
                    end
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they track state_q exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            rem_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            sat_q       <= sat_d;
            in_ready_q  <= (state_d == ST_ACC);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = acc_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_fixed_point_acc_ctrl.sv
// Self-checking bench for fixed_point_acc_ctrl: directed scenarios plus
// randomized runs against an integer-arithmetic reference model.
module tb_fixed_point_acc_ctrl;

    localparam int BW   = 20;
    localparam int MW   = BW - 1;
    localparam int CW   = 5;
    localparam int ML   = 16;
    localparam int MAXM = (1 << MW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] len;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          busy;
    logic          sat_flag;

    int n_cmp = 0;
    int n_bad = 0;
    logic [BW-1:0] ops [0:31];

    always #5 clk = ~clk;

    fixed_point_acc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .sat_flag  (sat_flag)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed integer sum clamped to +-MAXM; a zero result keeps the accumulator sign.
    task automatic model(input int n, output logic [BW-1:0] res, output logic sat);
        int a;
        int s;
        int nb;
        logic neg;
        a = 0; neg = 1'b0; sat = 1'b0;
        nb = (n > ML) ? ML : n;
        for (int k = 0; k < nb; k++) begin
            s = a + (ops[k][BW-1] ? -int'(ops[k][MW-1:0]) : int'(ops[k][MW-1:0]));
            if (s > MAXM) s = MAXM;
            else if (s < -MAXM) s = -MAXM;
            if (s != 0) neg = (s < 0);
            a = s;
            if (s == MAXM || s == -MAXM) sat = 1'b1;
        end
        res = {neg, MW'(neg ? -a : a)};
    endtask

    // Start a run and feed ops[] with random gaps; reports output state after the last beat.
    task automatic run_beats(input int n, input int gap_pct, output logic ov_ok,
                             output logic tmo, output int cyc);
        int k = 0;
        int nb;
        logic take;
        cyc = 0;
        nb = (n > ML) ? ML : n;
        start = 1'b1; len = CW'(n);
        tick();
        start = 1'b0; len = '0;
        while (k < nb && cyc < 400) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_data  = in_valid ? ops[k] : BW'($urandom);
            take     = in_valid && in_ready;
            tick();
            cyc++;
            if (take) k++;
        end
        in_valid = 1'b0;
        tmo   = (k < nb);
        ov_ok = out_valid;
    endtask

    task automatic finish_done(input int hold);
        out_ready = 1'b0;
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy, in_ready, out_valid, sat_flag} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 0000", {busy, in_ready, out_valid, sat_flag});
        end
        n_cmp++;
        if (out_data !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 00000", out_data);
        end
    endtask

    task automatic test_basic();
        logic ov, tmo; int cyc;
        ops[0] = 20'h10000; ops[1] = 20'h10000;
        run_beats(2, 0, ov, tmo, cyc);
        n_cmp++;
        if (tmo !== 1'b0 || ov !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_latency: tmo %b out_valid %b want 0 1", tmo, ov);
        end
        n_cmp++;
        if (out_data !== 20'h20000 || sat_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_data: got %h sat %b want 20000 sat 0", out_data, sat_flag);
        end
        finish_done(0);
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_handoff: busy %b out_valid %b want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_saturate();
        logic ov, tmo; int cyc;
        ops[0] = 20'h7FFFF; ops[1] = 20'h10000;
        run_beats(2, 0, ov, tmo, cyc);
        n_cmp++;
        if (ov !== 1'b1 || out_data !== 20'h7FFFF || sat_flag !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_data: ov %b got %h sat %b want 1 7ffff 1", ov, out_data, sat_flag);
        end
        finish_done(1);
        n_cmp++;
        if (sat_flag !== 1'b1 || out_data !== 20'h7FFFF || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_idle: sat %b data %h busy %b want 1 7ffff 0", sat_flag, out_data, busy);
        end
    endtask

    task automatic test_len_zero();
        logic ov, tmo; int cyc;
        run_beats(0, 0, ov, tmo, cyc);
        n_cmp++;
        if (ov !== 1'b1 || in_ready !== 1'b0 || out_data !== 20'h00000 || sat_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL len0: ov %b rdy %b data %h sat %b want 1 0 00000 0",
                     ov, in_ready, out_data, sat_flag);
        end
        finish_done(0);
    endtask

    task automatic test_cancel();
        logic ov, tmo; int cyc;
        logic [BW-1:0] exp_d; logic exp_s;
        ops[0] = 20'h40000; ops[1] = 20'hC0000;
        run_beats(2, 0, ov, tmo, cyc);
        n_cmp++;
        if (ov !== 1'b1 || out_data[MW-1:0] !== '0 || sat_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL cancel_mag: ov %b data %h sat %b want 1 mag0 0", ov, out_data, sat_flag);
        end
        finish_done(0);
        ops[0] = 20'h80003; ops[1] = 20'h00003;
        model(2, exp_d, exp_s);
        run_beats(2, 0, ov, tmo, cyc);
        n_cmp++;
        if (out_data !== exp_d || sat_flag !== exp_s) begin
            n_bad++;
            $display("FAIL neg_zero: got %h sat %b want %h sat %b", out_data, sat_flag, exp_d, exp_s);
        end
        finish_done(0);
    endtask

    task automatic test_backpressure();
        logic ov, tmo; int cyc;
        logic [BW-1:0] exp_d; logic exp_s;
        for (int k = 0; k < 3; k++) ops[k] = {1'($urandom_range(1)), MW'($urandom_range(65535))};
        model(3, exp_d, exp_s);
        run_beats(3, 50, ov, tmo, cyc);
        n_cmp++;
        if (tmo !== 1'b0 || ov !== 1'b1 || out_data !== exp_d || sat_flag !== exp_s) begin
            n_bad++;
            $display("FAIL bp_result: tmo %b ov %b got %h sat %b want %h sat %b",
                     tmo, ov, out_data, sat_flag, exp_d, exp_s);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = (i == 1); len = CW'(1);
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp_d) begin
                n_bad++;
                $display("FAIL bp_hold%0d: ov %b rdy %b data %h want 1 0 %h",
                         i, out_valid, in_ready, out_data, exp_d);
            end
        end
        start = 1'b1; len = CW'(2); out_ready = 1'b1;
        tick();
        start = 1'b0; len = '0; out_ready = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== exp_d) begin
            n_bad++;
            $display("FAIL bp_idle: busy %b ov %b rdy %b data %h want 0 0 0 %h",
                     busy, out_valid, in_ready, out_data, exp_d);
        end
    endtask

    task automatic test_reset_mid();
        logic ov, tmo; int cyc;
        logic seen_ov = 1'b0;
        ops[0] = 20'h01234; ops[1] = 20'h02345;
        start = 1'b1; len = CW'(4);
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = ops[k];
            tick();
        end
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy, in_ready, out_valid, sat_flag} !== 4'b0 || out_data !== '0) begin
            n_bad++;
            $display("FAIL rstmid_outs: flags %b data %h want 0000 00000",
                     {busy, in_ready, out_valid, sat_flag}, out_data);
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 20'h00100;
            tick();
            seen_ov = seen_ov | out_valid | busy;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (seen_ov !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_quiet: got activity %b want 0", seen_ov);
        end
        ops[0] = 20'h00001;
        run_beats(1, 0, ov, tmo, cyc);
        n_cmp++;
        if (ov !== 1'b1 || out_data !== 20'h00001) begin
            n_bad++;
            $display("FAIL rstmid_fresh: ov %b got %h want 1 00001", ov, out_data);
        end
        finish_done(0);
    endtask

    task automatic test_random();
        logic ov, tmo; int cyc; int n;
        logic [BW-1:0] exp_d; logic exp_s;
        logic [MW-1:0] mag;
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(20);
            for (int k = 0; k < ML; k++) begin
                case ($urandom_range(3))
                    0:       mag = MW'($urandom);
                    3:       mag = '0;
                    default: mag = MW'($urandom_range(65535));
                endcase
                ops[k] = {1'($urandom_range(1)), mag};
            end
            model(n, exp_d, exp_s);
            run_beats(n, 30, ov, tmo, cyc);
            n_cmp++;
            if (tmo !== 1'b0 || ov !== 1'b1 || out_data !== exp_d || sat_flag !== exp_s) begin
                n_bad++;
                $display("FAIL rand%0d len %0d: tmo %b ov %b got %h sat %b want %h sat %b",
                         r, n, tmo, ov, out_data, sat_flag, exp_d, exp_s);
            end
            finish_done($urandom_range(2));
            n_cmp++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rand%0d_idle: busy %b ov %b want 0 0", r, busy, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ov, tmo; int cyc;
        logic [BW-1:0] exp_d; logic exp_s;
        for (int k = 0; k < ML; k++) ops[k] = {1'b0, MW'($urandom_range(4095))};
        model(ML, exp_d, exp_s);
        run_beats(ML, 0, ov, tmo, cyc);
        n_cmp++;
        if (cyc != ML || ov !== 1'b1 || out_data !== exp_d) begin
            n_bad++;
            $display("FAIL b2b_rate: cycles %0d ov %b got %h want %0d 1 %h", cyc, ov, out_data, ML, exp_d);
        end
        finish_done(0);
        for (int k = 0; k < ML; k++) ops[k] = {1'b1, MW'($urandom_range(4095))};
        model(ML, exp_d, exp_s);
        run_beats(ML, 0, ov, tmo, cyc);
        n_cmp++;
        if (cyc != ML || ov !== 1'b1 || out_data !== exp_d || sat_flag !== exp_s) begin
            n_bad++;
            $display("FAIL b2b_second: cycles %0d got %h sat %b want %0d %h sat %b",
                     cyc, out_data, sat_flag, ML, exp_d, exp_s);
        end
        finish_done(0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        in_data = '0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_saturate();
        test_len_zero();
        test_cancel();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
